// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake direction/length controller.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_RIGHT = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DEAD = 2'b10
    } ctrl_state_t;

    localparam int unsigned SizeW = 6;

    // Directions are encoded so that the opposite is the bitwise inverse.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(~d);
    endfunction

endpackage

// File: rtl/key_edge.sv
// One push-button path: 2-flop synchronizer followed by a rising-edge pulse.
module key_edge (
    input  logic clk,
    input  logic reset,
    input  logic key_i,
    output logic press_o
);

    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign press_o = sync2_q & ~prev_q;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake control stage: key decoding, direction commit per step, length tracking and step strobe.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 256,
    parameter int unsigned INIT_SIZE   = 3,
    parameter int unsigned MAX_SIZE    = 63
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_up,
    input  logic             key_left,
    input  logic             key_right,
    input  logic             key_down,
    input  logic             apple_eaten,
    input  logic             game_over,
    output logic [1:0]       next_dir,
    output logic [SizeW-1:0] size,
    output logic             step,
    output logic             running
);

    localparam int unsigned CntW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CntW-1:0]  CntLast  = CntW'(STEP_CYCLES - 1);
    localparam logic [SizeW-1:0] SizeInit = SizeW'(INIT_SIZE);
    localparam logic [SizeW-1:0] SizeMax  = SizeW'(MAX_SIZE);

    logic [3:0] press;

    key_edge u_key_up (
        .clk     (clk),
        .reset   (reset),
        .key_i   (key_up),
        .press_o (press[3])
    );

    key_edge u_key_left (
        .clk     (clk),
        .reset   (reset),
        .key_i   (key_left),
        .press_o (press[2])
    );

    key_edge u_key_right (
        .clk     (clk),
        .reset   (reset),
        .key_i   (key_right),
        .press_o (press[1])
    );

    key_edge u_key_down (
        .clk     (clk),
        .reset   (reset),
        .key_i   (key_down),
        .press_o (press[0])
    );

    ctrl_state_t      state_q, state_d;
    dir_t             next_dir_q, next_dir_d;
    dir_t             pending_q, pending_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [SizeW-1:0] size_q, size_d;

    logic req_valid;
    dir_t req_dir;
    logic step_cycle;

    // Fixed priority: up > left > right > down.
    always_comb begin
        req_valid = |press;
        req_dir   = DIR_UP;
        if (press[3]) begin
            req_dir = DIR_UP;
        end else if (press[2]) begin
            req_dir = DIR_LEFT;
        end else if (press[1]) begin
            req_dir = DIR_RIGHT;
        end else if (press[0]) begin
            req_dir = DIR_DOWN;
        end
    end

    assign step_cycle = (state_q == RUN) && (cnt_q == CntLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            next_dir_q <= DIR_UP;
            pending_q  <= DIR_UP;
            cnt_q      <= '0;
            size_q     <= SizeInit;
        end else begin
            state_q    <= state_d;
            next_dir_q <= next_dir_d;
            pending_q  <= pending_d;
            cnt_q      <= cnt_d;
            size_q     <= size_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        next_dir_d = next_dir_q;
        pending_d  = pending_q;
        cnt_d      = cnt_q;
        size_d     = size_q;
        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                size_d = SizeInit;
                if (req_valid) begin
                    next_dir_d = req_dir;
                    pending_d  = req_dir;
                    state_d    = RUN;
                end
            end
            RUN: begin
                // game_over freezes everything else on this edge.
                if (game_over) begin
                    state_d = DEAD;
                end else begin
                    cnt_d = step_cycle ? '0 : cnt_q + CntW'(1);
                    // Reversal is judged against the committed direction only.
                    if (req_valid && (req_dir != opposite(next_dir_q))) begin
                        pending_d = req_dir;
                    end
                    if (step_cycle) begin
                        next_dir_d = pending_q;
                    end
                    if (apple_eaten && (size_q != SizeMax)) begin
                        size_d = size_q + SizeW'(1);
                    end
                end
            end
            DEAD: begin
                if (req_valid && !game_over) begin
                    state_d = IDLE;
                    size_d  = SizeInit;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        step    = step_cycle;
        running = (state_q == RUN);
    end

    assign next_dir = next_dir_q;
    assign size     = size_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Self-checking bench for snake_dir_ctrl with a short step period.
module tb_snake_dir_ctrl;

    localparam int unsigned StepCycles = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_up = 1'b0, key_left = 1'b0, key_right = 1'b0, key_down = 1'b0;
    logic       apple_eaten = 1'b0, game_over = 1'b0;
    logic [1:0] next_dir;
    logic [5:0] size;
    logic       step, running;

    snake_dir_ctrl #(
        .STEP_CYCLES (StepCycles),
        .INIT_SIZE   (3),
        .MAX_SIZE    (63)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_up      (key_up),
        .key_left    (key_left),
        .key_right   (key_right),
        .key_down    (key_down),
        .apple_eaten (apple_eaten),
        .game_over   (game_over),
        .next_dir    (next_dir),
        .size        (size),
        .step        (step),
        .running     (running)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] keys;  // {up, left, right, down}
        logic       apple;
        logic       go;
        logic       rst;
        logic       run;
        logic       stp;
        logic [1:0] dir;
        logic [5:0] sz;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] care;  // {run, step, dir, size}
        logic       run;
        logic       stp;
        logic [1:0] dir;
        logic [5:0] sz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_keys(input logic [3:0] k);
        key_up    = k[3];
        key_left  = k[2];
        key_right = k[1];
        key_down  = k[0];
    endtask

    task automatic push_exp(input string nm, input logic [3:0] care, input logic r,
                            input logic s, input logic [1:0] d, input logic [5:0] z);
        exp_t e;
        e.name = nm;
        e.care = care;
        e.run  = r;
        e.stp  = s;
        e.dir  = d;
        e.sz   = z;
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        logic ok;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: no expected entry queued");
        end else begin
            e  = sb.pop_front();
            ok = 1'b1;
            if (e.care[3] && running !== e.run) ok = 1'b0;
            if (e.care[2] && step !== e.stp) ok = 1'b0;
            if (e.care[1] && next_dir !== e.dir) ok = 1'b0;
            if (e.care[0] && size !== e.sz) ok = 1'b0;
            if (!ok) begin
                n_fail++;
                $display("FAIL %s: got running=%0d step=%0d dir=%0d size=%0d, want running=%0d step=%0d dir=%0d size=%0d (care=%b)",
                         e.name, running, step, next_dir, size, e.run, e.stp, e.dir, e.sz, e.care);
            end
        end
    endtask

    task automatic expect_now(input string nm, input logic [3:0] care, input logic r,
                              input logic s, input logic [1:0] d, input logic [5:0] z);
        push_exp(nm, care, r, s, d, z);
        compare_out();
    endtask

    // Key high for one edge; the press is consumed on the third edge.
    task automatic press(input logic [3:0] k);
        set_keys(k);
        tick();
        set_keys(4'b0000);
        tick();
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_step(input string nm);
        int budget;
        budget = 2 * StepCycles + 4;
        while (step !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        if (step !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: step never rose, got 0 want 1", nm);
        end
    endtask

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 6'd3};
        tbl[1]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd3};
        tbl[2]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd3};
        tbl[3]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 6'd3};
        for (int i = 4; i <= 9; i++) begin
            tbl[i] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 6'd3};
        end
        tbl[10] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 6'd3};
        tbl[11] = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 6'd4};
        tbl[12] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 6'd4};

        for (int i = 0; i < 13; i++) begin
            set_keys(tbl[i].keys);
            apple_eaten = tbl[i].apple;
            game_over   = tbl[i].go;
            reset       = tbl[i].rst;
            push_exp($sformatf("vec%0d", i), 4'b1111, tbl[i].run, tbl[i].stp, tbl[i].dir,
                     tbl[i].sz);
            tick();
            compare_out();
        end
        apple_eaten = 1'b0;

        // Reversal rejection and once-per-step commit.
        do_reset();
        press(4'b1000);
        expect_now("start_up", 4'b1111, 1'b1, 1'b0, 2'd0, 6'd3);
        press(4'b0001);
        for (int k = 0; k < 3; k++) begin
            wait_step("rev_wait");
            expect_now("down_rejected_step", 4'b0110, 1'b0, 1'b1, 2'd0, 6'd0);
            tick();
            expect_now("down_rejected_after", 4'b0010, 1'b0, 1'b0, 2'd0, 6'd0);
        end
        press(4'b0100);
        expect_now("left_pending", 4'b0010, 1'b0, 1'b0, 2'd0, 6'd0);
        wait_step("left_wait");
        expect_now("left_before_commit", 4'b0110, 1'b0, 1'b1, 2'd0, 6'd0);
        tick();
        expect_now("left_committed", 4'b0010, 1'b0, 1'b0, 2'd1, 6'd0);
        // Right is opposite the committed left, even though pending is up.
        press(4'b1000);
        press(4'b0010);
        wait_step("vs_committed_wait");
        tick();
        expect_now("check_vs_committed", 4'b0010, 1'b0, 1'b0, 2'd0, 6'd0);

        // Simultaneous presses from IDLE.
        do_reset();
        press(4'b0101);
        expect_now("prio_left_down", 4'b1010, 1'b1, 1'b0, 2'd1, 6'd0);
        do_reset();
        press(4'b1001);
        expect_now("prio_up_down", 4'b1011, 1'b1, 1'b0, 2'd0, 6'd3);

        // Growth, then game_over beating apple_eaten.
        apple_eaten = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            expect_now("grow", 4'b0001, 1'b0, 1'b0, 2'd0, 6'(4 + k));
        end
        game_over = 1'b1;
        tick();
        expect_now("apple_vs_go", 4'b1111, 1'b0, 1'b0, 2'd0, 6'd8);
        game_over = 1'b0;
        for (int k = 0; k < 2 * StepCycles; k++) begin
            tick();
            expect_now("dead_frozen", 4'b1111, 1'b0, 1'b0, 2'd0, 6'd8);
        end
        apple_eaten = 1'b0;
        press(4'b0100);
        expect_now("dead_to_idle", 4'b1111, 1'b0, 1'b0, 2'd0, 6'd3);
        apple_eaten = 1'b1;
        tick();
        expect_now("idle_ignores_apple", 4'b1001, 1'b0, 1'b0, 2'd0, 6'd3);
        apple_eaten = 1'b0;
        press(4'b0010);
        expect_now("idle_to_run", 4'b1011, 1'b1, 1'b0, 2'd2, 6'd3);

        // Size saturation.
        apple_eaten = 1'b1;
        for (int k = 1; k <= 65; k++) begin
            tick();
            expect_now("saturate", 4'b1001, 1'b1, 1'b0, 2'd0, (3 + k > 63) ? 6'd63 : 6'(3 + k));
        end
        apple_eaten = 1'b0;

        // Reset in a step cycle.
        wait_step("rst_wait");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_now("reset_mid_run", 4'b1111, 1'b0, 1'b0, 2'd0, 6'd3);
        for (int k = 0; k < 2 * StepCycles; k++) begin
            tick();
            expect_now("no_stray_step", 4'b1111, 1'b0, 1'b0, 2'd0, 6'd3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
- Upstream control stage for the per-cell snake light array.
- Turns four raw push-button inputs into a registered movement direction (next_dir).
- Maintains the snake length (size) and produces the movement step strobe that all cell lights consume.
- Enforces game rules: no 180-degree reversal, growth on apple, freeze on game over.

Parameters:
- STEP_CYCLES, 256, clock cycles per snake move (step period); minimum 2.
- INIT_SIZE, 3, snake length loaded at game start; 1..MAX_SIZE.
- MAX_SIZE, 63, saturation limit of size; must fit in 6 bits.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- key_up  in  1  raw button, active-high, asynchronous to clk
- key_left  in  1  raw button, active-high, asynchronous to clk
- key_right  in  1  raw button, active-high, asynchronous to clk
- key_down  in  1  raw button, active-high, asynchronous to clk
- apple_eaten  in  1  one-cycle pulse: head consumed an apple
- game_over  in  1  level or pulse: collision detected
- next_dir  out  2  committed direction; 00 up, 01 left, 10 right, 11 down
- size  out  6  current snake length
- step  out  1  one-cycle move strobe, active only in RUN
- running  out  1  high while the FSM is in RUN

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset. All state updates on posedge clk.
- Reset values: next_dir=00, size=INIT_SIZE, step=0, running=0, FSM=IDLE, step counter=0, pending_dir=00, synchronizers and edge registers=0.
- Key input path:
  - Each key passes through a 2-flop synchronizer and then a rising-edge detector (sync2 & ~prev).
  - A key high before edge N produces a press event in the cycle after edge N+1; the event is consumed at edge N+2.
  - Simultaneous presses resolve by priority: up > left > right > down. Only one request is taken per cycle.
- Reversal rule:
  - Opposite direction is the bitwise inverse (00<->11, 01<->10).
  - A request equal to ~next_dir is discarded and leaves pending_dir unchanged.
  - A request equal to next_dir is accepted; it has no visible effect.
- FSM state IDLE:
  - step=0, running=0, counter held at 0, size held at INIT_SIZE.
  - Any press event loads next_dir and pending_dir with the pressed direction and enters RUN. The reversal rule does not apply in IDLE.
- FSM state RUN:
  - running=1. The counter increments each cycle from 0 to STEP_CYCLES-1 and then wraps to 0.
  - step=1 combinationally during the cycle where counter==STEP_CYCLES-1.
  - pending_dir takes the latest accepted request. On the edge that ends a step cycle, next_dir <= pending_dir, so the direction changes at most once per step.
  - The reversal check always compares against the committed next_dir, not pending_dir. Example: with next_dir=up, left-then-down within one step gives pending=left; down is checked against up, is rejected, and pending stays left.
  - The first step pulse occurs STEP_CYCLES cycles after entering RUN.
- apple_eaten:
  - Acted on in RUN only: size <= size+1, saturating at MAX_SIZE. Ignored in IDLE and DEAD.
  - If it coincides with a step pulse, both take effect on the same edge.
- game_over:
  - In RUN, enters DEAD at the next edge. game_over has priority over apple_eaten and over a direction commit in the same cycle; neither the increment nor the commit occurs.
  - If game_over coincides with a step cycle, step is still high for that cycle, but next_dir does not update.
- FSM state DEAD:
  - running=0, step=0; next_dir, size and counter hold their values.
  - A press event while game_over is low returns to IDLE with size <= INIT_SIZE and counter <= 0. The press is consumed and does not start RUN.
- Reset mid-operation: every register returns to its reset value at the next edge, in any state. A press in flight in the synchronizers is lost.
- Widths:
  - Counter width is $clog2(STEP_CYCLES).
  - size arithmetic is 6-bit and never wraps.

Decomposition:
- Shared package snake_pkg holds:
  - dir_t, a 2-bit enum: DIR_UP=00, DIR_LEFT=01, DIR_RIGHT=10, DIR_DOWN=11.
  - A function opposite(dir_t), returning the bitwise inverse.
  - ctrl_state_t, an enum: IDLE, RUN, DEAD.
- Sub-module key_edge handles one key: 2-flop synchronizer plus rising-edge pulse. It is instantiated four times.

Test Plan:
- Reset, then raise key_right at cycle 5 (STEP_CYCLES=8): running=1 from cycle 8, next_dir=10, first step at cycle 15, size=3.
- In RUN with next_dir=00 (up), press key_down: request rejected, next_dir stays 00 across 3 steps. Then press key_left: next_dir=01 exactly at the edge ending the next step cycle.
- Raise key_up and key_down in the same cycle from IDLE: next_dir=00, since up has priority.
- Pulse apple_eaten 62 times in RUN starting from INIT_SIZE=3: size climbs to 63 and holds at 63. Pulse apple_eaten together with game_over: size unchanged, FSM enters DEAD.
- Assert game_over in RUN: step stays low thereafter, running=0, next_dir and size frozen. Then press key_left: FSM goes to IDLE with size=3, and a second press enters RUN.
- Assert reset for one cycle mid-RUN while a step is due: step=0 and all outputs at reset values the following cycle; no stray step pulses.
